// File: rtl/jtag_tap_target.sv
`default_nettype none
// ============================================================================
// Module : jtag_tap_target
// Brief  : Clock-domain JTAG TAP responder; oversampled pins drive a 16-state
//          TAP FSM with IR, BYPASS, IDCODE and one user data register.
// Rev    : 1.0
// ============================================================================
module jtag_tap_target #(
  parameter int                  IR_WIDTH     = 5,
  parameter int                  DR_WIDTH     = 32,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0A6B,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(17)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] dr_rdata,
  output logic                dr_capture,
  output logic [DR_WIDTH-1:0] dr_wdata,
  output logic                dr_update
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PA_DR  = 4'h6, EX2_DR = 4'h7,
    UP_DR  = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PA_IR  = 4'hD, EX2_IR = 4'hE, UP_IR  = 4'hF
  } tap_state_t;

  logic [2:0]          r_tck_sync;
  logic [1:0]          r_tms_sync;
  logic [1:0]          r_tdi_sync;
  tap_state_t          r_state;
  tap_state_t          w_next;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_ir_out;
  logic [31:0]         r_idcode_shift;
  logic [DR_WIDTH-1:0] r_user_shift;
  logic [DR_WIDTH-1:0] r_dr_wdata;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_dr_capture;
  logic                r_dr_update;

  logic w_rise;
  logic w_fall;
  logic w_tms;
  logic w_tdi;
  logic w_sel_idcode;
  logic w_sel_user;
  logic w_dr_lsb;

  // Bit 2 is only a delayed copy of the synchronized tck for edge detection.
  assign w_rise       =  r_tck_sync[1] & ~r_tck_sync[2];
  assign w_fall       = ~r_tck_sync[1] &  r_tck_sync[2];
  assign w_tms        = r_tms_sync[1];
  assign w_tdi        = r_tdi_sync[1];
  assign w_sel_idcode = (r_ir_out == INSTR_IDCODE);
  assign w_sel_user   = (r_ir_out == INSTR_USER);
  assign w_dr_lsb     = w_sel_idcode ? r_idcode_shift[0] :
                        w_sel_user   ? r_user_shift[0]   : r_bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_state    <= TLR;
    end else begin
      r_tck_sync <= {r_tck_sync[1:0], tck};
      r_tms_sync <= {r_tms_sync[0], tms};
      r_tdi_sync <= {r_tdi_sync[0], tdi};
      r_state    <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      case (r_state)
        TLR:     w_next = w_tms ? TLR    : RTI;
        RTI:     w_next = w_tms ? SEL_DR : RTI;
        SEL_DR:  w_next = w_tms ? SEL_IR : CAP_DR;
        CAP_DR:  w_next = w_tms ? EX1_DR : SH_DR;
        SH_DR:   w_next = w_tms ? EX1_DR : SH_DR;
        EX1_DR:  w_next = w_tms ? UP_DR  : PA_DR;
        PA_DR:   w_next = w_tms ? EX2_DR : PA_DR;
        EX2_DR:  w_next = w_tms ? UP_DR  : SH_DR;
        UP_DR:   w_next = w_tms ? SEL_DR : RTI;
        SEL_IR:  w_next = w_tms ? TLR    : CAP_IR;
        CAP_IR:  w_next = w_tms ? EX1_IR : SH_IR;
        SH_IR:   w_next = w_tms ? EX1_IR : SH_IR;
        EX1_IR:  w_next = w_tms ? UP_IR  : PA_IR;
        PA_IR:   w_next = w_tms ? EX2_IR : PA_IR;
        EX2_IR:  w_next = w_tms ? UP_IR  : SH_IR;
        UP_IR:   w_next = w_tms ? SEL_DR : RTI;
        default: w_next = TLR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_shift     <= '0;
      r_ir_out       <= INSTR_IDCODE;
      r_idcode_shift <= '0;
      r_user_shift   <= '0;
      r_dr_wdata     <= '0;
      r_bypass       <= 1'b0;
      r_tdo          <= 1'b0;
      r_dr_capture   <= 1'b0;
      r_dr_update    <= 1'b0;
    end else begin
      r_dr_capture <= 1'b0;
      r_dr_update  <= 1'b0;
      if (w_rise) begin
        case (r_state)
          TLR:    r_ir_out   <= INSTR_IDCODE;
          CAP_IR: r_ir_shift <= IR_WIDTH'(1);
          SH_IR:  r_ir_shift <= {w_tdi, r_ir_shift[IR_WIDTH-1:1]};
          UP_IR:  r_ir_out   <= r_ir_shift;
          CAP_DR: begin
            if (w_sel_idcode) begin
              r_idcode_shift <= IDCODE_VAL;
            end else if (w_sel_user) begin
              r_user_shift <= dr_rdata;
              r_dr_capture <= 1'b1;
            end else begin
              r_bypass <= 1'b0;
            end
          end
          SH_DR: begin
            if (w_sel_idcode) begin
              r_idcode_shift <= {w_tdi, r_idcode_shift[31:1]};
            end else if (w_sel_user) begin
              r_user_shift <= {w_tdi, r_user_shift[DR_WIDTH-1:1]};
            end else begin
              r_bypass <= w_tdi;
            end
          end
          UP_DR: begin
            if (w_sel_user) begin
              r_dr_wdata  <= r_user_shift;
              r_dr_update <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // tdo only moves on falling tck so it is stable across the next rising edge.
      if (w_fall) begin
        case (r_state)
          SH_IR:   r_tdo <= r_ir_shift[0];
          SH_DR:   r_tdo <= w_dr_lsb;
          default: r_tdo <= 1'b0;
        endcase
      end
    end
  end

  assign tdo        = r_tdo;
  assign tap_state  = r_state;
  assign ir_out     = r_ir_out;
  assign dr_capture = r_dr_capture;
  assign dr_wdata   = r_dr_wdata;
  assign dr_update  = r_dr_update;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_target.sv
`default_nettype none
// ============================================================================
// Module : tb_jtag_tap_target
// Brief  : Directed and randomized JTAG scans against a behavioural TAP model.
// Rev    : 1.0
// ============================================================================
module tb_jtag_tap_target;
  localparam int          IRW = 5;
  localparam int          DRW = 32;
  localparam logic [31:0] IDC = 32'h1000_0A6B;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tck = 1'b0;
  logic           tms = 1'b0;
  logic           tdi = 1'b0;
  logic           tdo;
  logic [3:0]     tap_state;
  logic [IRW-1:0] ir_out;
  logic [DRW-1:0] dr_rdata = '0;
  logic           dr_capture;
  logic [DRW-1:0] dr_wdata;
  logic           dr_update;

  jtag_tap_target dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .ir_out(ir_out), .dr_rdata(dr_rdata),
    .dr_capture(dr_capture), .dr_wdata(dr_wdata), .dr_update(dr_update)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // IEEE 1149.1 next-state table indexed by state code, one array per tms value.
  logic [3:0] nxt0[16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                           4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
  logic [3:0] nxt1[16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                           4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

  logic [3:0]  m_state;
  logic [4:0]  m_ir, m_irs;
  logic [31:0] m_idc, m_usr, m_wdata;
  logic        m_byp, m_tdo, exp_cap, exp_upd;
  int          n_cap = 0, n_upd = 0, d_cap = 0, d_upd = 0;
  time         t_chg = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 4'd0; m_ir = 5'h01; m_irs = '0; m_idc = '0; m_usr = '0;
    m_wdata = '0; m_byp = 1'b0; m_tdo = 1'b0; exp_cap = 1'b0; exp_upd = 1'b0;
  endtask

  function automatic int m_sel();
    if (m_ir == 5'h01) return 1;
    if (m_ir == 5'h11) return 2;
    return 0;
  endfunction

  task automatic m_rise(input logic tms_v, input logic tdi_v);
    int sel;
    sel = m_sel();
    exp_cap = 1'b0;
    exp_upd = 1'b0;
    case (m_state)
      4'd0:  m_ir  = 5'h01;
      4'd10: m_irs = 5'b00001;
      4'd11: m_irs = {tdi_v, m_irs[4:1]};
      4'd15: m_ir  = m_irs;
      4'd3: begin
        if (sel == 1) m_idc = IDC;
        else if (sel == 2) begin m_usr = dr_rdata; exp_cap = 1'b1; n_cap++; end
        else m_byp = 1'b0;
      end
      4'd4: begin
        if (sel == 1) m_idc = {tdi_v, m_idc[31:1]};
        else if (sel == 2) m_usr = {tdi_v, m_usr[31:1]};
        else m_byp = tdi_v;
      end
      4'd8: if (sel == 2) begin m_wdata = m_usr; exp_upd = 1'b1; n_upd++; end
      default: ;
    endcase
    m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
  endtask

  task automatic m_fall();
    int sel;
    sel = m_sel();
    exp_cap = 1'b0;
    exp_upd = 1'b0;
    if (m_state == 4'd11) m_tdo = m_irs[0];
    else if (m_state == 4'd4) m_tdo = (sel == 1) ? m_idc[0] : (sel == 2) ? m_usr[0] : m_byp;
    else m_tdo = 1'b0;
  endtask

  // Pins change at t_chg; DUT outputs are settled from the 4th negedge onward,
  // and strobes must be high on exactly that first settled negedge.
  always @(negedge clk) begin
    time age;
    if (chk_en) begin
      age = $time - t_chg;
      if (dr_capture === 1'b1) d_cap++;
      if (dr_update === 1'b1) d_upd++;
      chk("dr_capture", 32'(dr_capture), 32'((age == 34) ? exp_cap : 1'b0));
      chk("dr_update", 32'(dr_update), 32'((age == 34) ? exp_upd : 1'b0));
      if (age >= 34) begin
        chk("tap_state", 32'(tap_state), 32'(m_state));
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("tdo", 32'(tdo), 32'(m_tdo));
        chk("dr_wdata", dr_wdata, m_wdata);
      end
    end
  end

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_o);
    @(posedge clk); #1;
    tms = tms_v; tdi = tdi_v; tck = 1'b1; m_rise(tms_v, tdi_v); t_chg = $time;
    repeat (6) @(posedge clk);
    #1; tck = 1'b0; m_fall(); t_chg = $time;
    repeat (6) @(posedge clk);
    #1; tdo_o = tdo;
  endtask

  task automatic goto_tlr();
    logic b;
    repeat (5) tck_cycle(1'b1, 1'b0, b);
  endtask

  // Start from TLR or RTI, end in RTI; dout collects tdo LSB-first.
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout,
                         input bit chk_ex1);
    logic b;
    dout = '0;
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      dout[i] = b;
      tck_cycle(i == n - 1, din[i], b);
    end
    if (chk_ex1) chk("ex1_dr literal", 32'(tap_state), 32'd5);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic ir_scan(input logic [4:0] v, output logic [4:0] cap);
    logic b;
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      cap[i] = b;
      tck_cycle(i == 4, v[i], b);
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  initial begin
    logic [63:0] dout;
    logic [4:0]  cap;
    logic        b;
    int          c0, u0, n;
    logic [4:0]  irv;

    m_reset();
    @(posedge clk); #1;
    chk_en = 1'b1; t_chg = $time;
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset tap_state", 32'(tap_state), 32'd0);
    chk("reset ir_out", 32'(ir_out), 32'h01);
    chk("reset tdo", 32'(tdo), 32'd0);
    chk("reset strobes", 32'({dr_capture, dr_update}), 32'd0);

    // Walk into SH_DR, then five tms=1 edges must land in TLR.
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    chk("in sh_dr", 32'(tap_state), 32'd4);
    goto_tlr();
    chk("tms5 to tlr", 32'(tap_state), 32'd0);

    dr_scan(32, {$urandom, $urandom}, dout, 1'b1);
    chk("idcode stream", dout[31:0], IDC);

    ir_scan(5'h11, cap);
    chk("ir capture", 32'(cap), 32'h01);
    chk("ir_out user", 32'(ir_out), 32'h11);

    dr_rdata = 32'hCAFE_F00D;
    c0 = d_cap; u0 = d_upd;
    dr_scan(32, 64'hDEAD_BEEF, dout, 1'b0);
    chk("user stream", dout[31:0], 32'hCAFE_F00D);
    chk("user capture count", 32'(d_cap - c0), 32'd1);
    chk("user update count", 32'(d_upd - u0), 32'd1);
    chk("user wdata", dr_wdata, 32'hDEAD_BEEF);

    ir_scan(5'h1F, cap);
    u0 = d_upd;
    dr_scan(4, 64'b1101, dout, 1'b0);
    chk("bypass stream", dout[31:0], 32'b1010);
    chk("bypass no update", 32'(d_upd - u0), 32'd0);

    // Reset lands in the same clk as a shift rising event, mid USER scan.
    ir_scan(5'h11, cap);
    dr_rdata = $urandom;
    u0 = d_upd;
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom), b);
    @(posedge clk); #1;
    tms = 1'b0; tdi = 1'($urandom); tck = 1'b1; t_chg = $time;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; m_reset(); t_chg = $time;
    repeat (3) @(posedge clk); #1; tck = 1'b0;
    repeat (3) @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("midreset tap_state", 32'(tap_state), 32'd0);
    chk("midreset ir_out", 32'(ir_out), 32'h01);
    chk("midreset wdata", dr_wdata, 32'd0);
    goto_tlr();
    chk("midreset no update", 32'(d_upd - u0), 32'd0);

    for (int r = 0; r < 10; r++) begin
      goto_tlr();
      case ($urandom_range(0, 3))
        0:       irv = 5'h01;
        1:       irv = 5'h11;
        2:       irv = 5'h1F;
        default: irv = 5'($urandom);
      endcase
      if (r < 3) irv = 5'h11;
      ir_scan(irv, cap);
      dr_rdata = $urandom;
      n = $urandom_range(1, 40);
      dr_scan(n, {$urandom, $urandom}, dout, 1'b0);
      for (int k = 0; k < 15; k++) begin
        dr_rdata = $urandom;
        tck_cycle($urandom_range(0, 2) == 0, 1'($urandom), b);
      end
    end

    chk("capture pulses", 32'(d_cap), 32'(n_cap));
    chk("update pulses", 32'(d_upd), 32'(n_upd));
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
